// File: rtl/instr_encoder_loader_pkg.sv
// ISA definitions shared by the encoder/loader and the instruction decoder:
// mnemonic codes, opcode/funct map, loader FSM states and word-packing helpers.
package isa_pkg;

    typedef enum logic [4:0] {
        MnAdd, MnAddu, MnSub, MnSubu, MnAnd, MnOr, MnXor, MnSlt,
        MnSll, MnSrl, MnSra, MnMul, MnJr,
        MnAddi, MnAddiu, MnAndi, MnOri, MnXori, MnSlti, MnLui,
        MnLw, MnSw, MnBeq, MnBne, MnBgt, MnBlt, MnBlte, MnBltu, MnBgtu,
        MnJ, MnJal, MnBgte
    } mnem_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFull,
        StDone
    } load_state_e;

    localparam logic [5:0] OpSpecial = 6'b000000;
    localparam logic [5:0] OpAddi    = 6'b001000;
    localparam logic [5:0] OpAddiu   = 6'b001001;
    localparam logic [5:0] OpAndi    = 6'b001100;
    localparam logic [5:0] OpOri     = 6'b001101;
    localparam logic [5:0] OpXori    = 6'b001110;
    localparam logic [5:0] OpSlti    = 6'b001010;
    localparam logic [5:0] OpLui     = 6'b001111;
    localparam logic [5:0] OpLw      = 6'b100011;
    localparam logic [5:0] OpSw      = 6'b101011;
    localparam logic [5:0] OpBeq     = 6'b000100;
    localparam logic [5:0] OpBne     = 6'b000101;
    localparam logic [5:0] OpBgt     = 6'b111000;
    localparam logic [5:0] OpBlt     = 6'b111001;
    localparam logic [5:0] OpBlte    = 6'b111010;
    localparam logic [5:0] OpBltu    = 6'b111011;
    localparam logic [5:0] OpBgtu    = 6'b111100;
    localparam logic [5:0] OpJ       = 6'b000010;
    localparam logic [5:0] OpJal     = 6'b000011;

    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnAddu = 6'b100001;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnSubu = 6'b100011;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnMul  = 6'b011000;
    localparam logic [5:0] FnJr   = 6'b001000;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OpSpecial, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm16);
        return {op, rs, rt, imm16};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] addr26);
        return {op, addr26};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Symbolic-instruction valid/ready stream from the program loader into the encoder.
interface instr_encoder_loader_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] addr26;

    modport master (
        output in_valid, mnem, rs, rt, rd, shamt, imm16, addr26,
        input  in_ready
    );

    modport slave (
        input  in_valid, mnem, rs, rt, rd, shamt, imm16, addr26,
        output in_ready
    );

endinterface

// File: rtl/instr_encoder_loader_pack.sv
// Pure combinational packer: mnemonic plus fields into a 32-bit MIPS word.
// Unknown mnemonics (BGTE, whose opcode aliases LUI) yield word 0 with legal low.
module instr_pack
    import isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm16,
    input  logic [25:0] addr26,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = 32'h0000_0000;
        legal = 1'b1;
        unique case (mnem_e'(mnem))
            MnAdd:   word = enc_r(rs, rt, rd, shamt, FnAdd);
            MnAddu:  word = enc_r(rs, rt, rd, shamt, FnAddu);
            MnSub:   word = enc_r(rs, rt, rd, shamt, FnSub);
            MnSubu:  word = enc_r(rs, rt, rd, shamt, FnSubu);
            MnAnd:   word = enc_r(rs, rt, rd, shamt, FnAnd);
            MnOr:    word = enc_r(rs, rt, rd, shamt, FnOr);
            MnXor:   word = enc_r(rs, rt, rd, shamt, FnXor);
            MnSlt:   word = enc_r(rs, rt, rd, shamt, FnSlt);
            MnSll:   word = enc_r(rs, rt, rd, shamt, FnSll);
            MnSrl:   word = enc_r(rs, rt, rd, shamt, FnSrl);
            MnSra:   word = enc_r(rs, rt, rd, shamt, FnSra);
            // MUL writes HI/LO, so the rd field carries no destination
            MnMul:   word = enc_r(rs, rt, 5'd0, shamt, FnMul);
            MnJr:    word = enc_r(rs, 5'd0, 5'd0, 5'd0, FnJr);
            MnAddi:  word = enc_i(OpAddi, rs, rt, imm16);
            MnAddiu: word = enc_i(OpAddiu, rs, rt, imm16);
            MnAndi:  word = enc_i(OpAndi, rs, rt, imm16);
            MnOri:   word = enc_i(OpOri, rs, rt, imm16);
            MnXori:  word = enc_i(OpXori, rs, rt, imm16);
            MnSlti:  word = enc_i(OpSlti, rs, rt, imm16);
            MnLui:   word = enc_i(OpLui, 5'd0, rt, imm16);
            MnLw:    word = enc_i(OpLw, rs, rt, imm16);
            MnSw:    word = enc_i(OpSw, rs, rt, imm16);
            MnBeq:   word = enc_i(OpBeq, rs, rt, imm16);
            MnBne:   word = enc_i(OpBne, rs, rt, imm16);
            MnBgt:   word = enc_i(OpBgt, rs, rt, imm16);
            MnBlt:   word = enc_i(OpBlt, rs, rt, imm16);
            MnBlte:  word = enc_i(OpBlte, rs, rt, imm16);
            MnBltu:  word = enc_i(OpBltu, rs, rt, imm16);
            MnBgtu:  word = enc_i(OpBgtu, rs, rt, imm16);
            MnJ:     word = enc_j(OpJ, addr26);
            MnJal:   word = enc_j(OpJal, addr26);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions and writes them sequentially into instruction memory.
// Optional ENC_ILLEGAL_TRAP_EN: illegal mnemonics raise a sticky flag instead of writing NOP.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0,
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   finish,
    instr_encoder_loader_if.slave  in_if,
    output logic                   imem_we,
    output logic [AW-1:0]          imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [AW:0]            count,
    output logic                   full,
    output logic                   done
`ifdef ENC_ILLEGAL_TRAP_EN
    ,
    output logic                   illegal
`endif
);

    localparam logic [AW-1:0] BaseAddr = AW'(BASE_ADDR);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [AW:0]   DepthCnt = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LastCnt  = (AW + 1)'(DEPTH - 1);

    load_state_e   state_q;
    logic          ready_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [AW:0]   count_q;
    logic          full_q;
    logic          done_q;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        xfer;
    logic        write_ok;
    logic        last_slot;
    logic [AW:0] pending;

    instr_pack u_pack (
        .mnem   (in_if.mnem),
        .rs     (in_if.rs),
        .rt     (in_if.rt),
        .rd     (in_if.rd),
        .shamt  (in_if.shamt),
        .imm16  (in_if.imm16),
        .addr26 (in_if.addr26),
        .word   (pack_word),
        .legal  (pack_legal)
    );

    assign xfer = in_if.in_valid && ready_q;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign write_ok = xfer && pack_legal;
    assign illegal  = illegal_q;
`else
    logic unused_legal;
    assign unused_legal = pack_legal;
    assign write_ok     = xfer;
`endif

    // Words accepted so far include the one still in its write cycle
    assign pending   = count_q + {{AW{1'b0}}, we_q};
    assign last_slot = write_ok && (pending == LastCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= BaseAddr;
            wdata_q   <= 32'h0000_0000;
            count_q   <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            if (we_q) begin
                if (addr_q != LastAddr) addr_q <= addr_q + 1'b1;
                if (count_q != DepthCnt) count_q <= count_q + 1'b1;
            end
            if (start) begin
                // Re-arm from any state; a same-cycle transfer is discarded
                state_q   <= StLoad;
                ready_q   <= 1'b1;
                addr_q    <= BaseAddr;
                count_q   <= '0;
                full_q    <= 1'b0;
                done_q    <= 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
                illegal_q <= 1'b0;
`endif
            end else begin
                if (write_ok) begin
                    we_q    <= 1'b1;
                    wdata_q <= pack_word;
                end
`ifdef ENC_ILLEGAL_TRAP_EN
                if (xfer && !pack_legal) illegal_q <= 1'b1;
`endif
                case (state_q)
                    StLoad: begin
                        if (last_slot) full_q <= 1'b1;
                        if (finish) begin
                            state_q <= StDone;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (last_slot) begin
                            state_q <= StFull;
                            ready_q <= 1'b0;
                        end
                    end
                    StFull: begin
                        if (finish) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_if.in_ready = ready_q;
    assign imem_we        = we_q;
    assign imem_addr      = addr_q;
    assign imem_wdata     = wdata_q;
    assign count          = count_q;
    assign full           = full_q;
    assign done           = done_q;

endmodule
